// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Brief    : Execute/writeback sequencer around a combinational ALU; computes
//            S/Z/C/V and owns the architectural status register.
//            Optional macro: ALU_EXEC_DIV0_TRAP_EN (divide-by-zero trap).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int WIDTH = 16,
    parameter int BITS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [BITS-1:0]  in_opcode,
    input  logic             in_use_carry,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [BITS-1:0]  alu_opcode,
    output logic             alu_c_in,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_illegal,
    output logic             out_trap,
    output logic [3:0]       status,
    output logic [15:0]      retired
);

    localparam logic [BITS-1:0] c_OP_ADD        = BITS'(0);
    localparam logic [BITS-1:0] c_OP_SUB        = BITS'(1);
    localparam logic [BITS-1:0] c_OP_MULT       = BITS'(2);
`ifdef ALU_EXEC_DIV0_TRAP_EN
    localparam logic [BITS-1:0] c_OP_DIV        = BITS'(3);
`endif
    localparam logic [BITS-1:0] c_OP_LAST_LEGAL = BITS'(11);
    localparam int              c_FLAG_C        = 1;

    logic             r_e_valid;
    logic [WIDTH-1:0] r_e_a;
    logic [WIDTH-1:0] r_e_b;
    logic [BITS-1:0]  r_e_opcode;
    logic             r_e_use_carry;
    logic             r_w_valid;
    logic [WIDTH-1:0] r_w_result;
    logic             r_w_illegal;
    logic             r_w_trap;
    logic [3:0]       r_status;
    logic [15:0]      r_retired;

    logic             w_e_adv;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_c_in;
    logic             w_legal;
    logic             w_trap;
    logic             w_add_c;
    logic             w_sub_c;
    logic             w_mul_ovf;
    logic             w_flag_c;
    logic             w_flag_v;
    logic             w_write_status;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_wb_result;

    assign w_e_adv    = r_e_valid && (!r_w_valid || out_ready);
    assign in_ready   = !r_e_valid || w_e_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_w_valid && out_ready;

    // Carry-in comes from the registered flags so back-to-back chains need no stall.
    assign w_c_in  = r_e_use_carry & r_status[c_FLAG_C];
    assign w_legal = (r_e_opcode <= c_OP_LAST_LEGAL);

`ifdef ALU_EXEC_DIV0_TRAP_EN
    assign w_trap = (r_e_opcode == c_OP_DIV) && (r_e_b == '0);
`else
    assign w_trap = 1'b0;
`endif

    // Comparisons against all-ones pick out the carry / high-half without slicing wide sums.
    assign w_add_c   = ({1'b0, r_e_a} + {1'b0, r_e_b} + {{WIDTH{1'b0}}, w_c_in})
                       > {1'b0, {WIDTH{1'b1}}};
    assign w_sub_c   = {1'b0, r_e_a} < ({1'b0, r_e_b} + {{WIDTH{1'b0}}, w_c_in});
    assign w_mul_ovf = ({{WIDTH{1'b0}}, r_e_a} * {{WIDTH{1'b0}}, r_e_b})
                       > {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

    always_comb begin
        w_flag_c = 1'b0;
        w_flag_v = 1'b0;
        case (r_e_opcode)
            c_OP_ADD: begin
                w_flag_c = w_add_c;
                w_flag_v = (r_e_a[WIDTH-1] == r_e_b[WIDTH-1]) &&
                           (alu_result[WIDTH-1] != r_e_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_flag_c = w_sub_c;
                w_flag_v = (r_e_a[WIDTH-1] != r_e_b[WIDTH-1]) &&
                           (alu_result[WIDTH-1] != r_e_a[WIDTH-1]);
            end
            c_OP_MULT: begin
                w_flag_c = w_mul_ovf;
                w_flag_v = w_mul_ovf;
            end
            default: ;
        endcase
    end

    assign w_flags = {alu_result[WIDTH-1], (alu_result == '0), w_flag_c, w_flag_v};

    always_comb begin
        w_wb_result = alu_result;
        if (!w_legal) begin
            w_wb_result = '0;
        end else if (w_trap) begin
            w_wb_result = '1;
        end
    end

    assign w_write_status = w_e_adv && w_legal && !w_trap && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid     <= 1'b0;
            r_e_a         <= '0;
            r_e_b         <= '0;
            r_e_opcode    <= '0;
            r_e_use_carry <= 1'b0;
        end else begin
            if (flush) begin
                r_e_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_e_valid <= 1'b1;
            end else if (w_e_adv) begin
                r_e_valid <= 1'b0;
            end
            if (w_in_fire && !flush) begin
                r_e_a         <= in_a;
                r_e_b         <= in_b;
                r_e_opcode    <= in_opcode;
                r_e_use_carry <= in_use_carry;
            end
        end
    end

    // W data only changes on e_adv, which implies the consumer is ready or W is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_valid   <= 1'b0;
            r_w_result  <= '0;
            r_w_illegal <= 1'b0;
            r_w_trap    <= 1'b0;
        end else begin
            if (flush) begin
                r_w_valid <= 1'b0;
            end else if (w_e_adv) begin
                r_w_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_w_valid <= 1'b0;
            end
            if (w_e_adv && !flush) begin
                r_w_result  <= w_wb_result;
                r_w_illegal <= !w_legal;
                r_w_trap    <= w_trap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status  <= 4'd0;
            r_retired <= 16'd0;
        end else begin
            if (w_write_status) begin
                r_status <= w_flags;
            end
            if (w_out_fire && !flush) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign alu_a       = r_e_a;
    assign alu_b       = r_e_b;
    assign alu_opcode  = r_e_opcode;
    assign alu_c_in    = w_c_in;
    assign out_valid   = r_w_valid;
    assign out_result  = r_w_result;
    assign out_illegal = r_w_illegal;
    assign out_trap    = r_w_trap;
    assign status      = r_status;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage sequencer wrapped around the combinational 16-bit ALU. It accepts decoded operations from the decode stage over a valid/ready handshake and registers the operands, opcode and carry-in that drive the ALU. It captures the ALU result together with flags it computes itself (S, Z, C, V) into a writeback register, and maintains the architectural status-flag register. Throughput is one operation per cycle.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- BITS, 4, opcode width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  decode has an operation
- in_ready  out  1  stage can accept an operation
- in_a, in_b  in  WIDTH  operands
- in_opcode  in  BITS  ALU opcode (0–11 legal)
- in_use_carry  in  1  1: C_in = status C; 0: C_in = 0
- alu_a, alu_b  out  WIDTH  registered operands to the ALU
- alu_opcode  out  BITS  registered opcode to the ALU
- alu_c_in  out  1  carry-in to the ALU
- alu_result  in  WIDTH  ALU combinational result
- out_valid  out  1  writeback register holds a result
- out_ready  in  1  writeback consumes the result
- out_result  out  WIDTH  captured result
- out_illegal  out  1  result came from an illegal opcode
- out_trap  out  1  divide-by-zero trap (see Configuration)
- status  out  4  architectural flags {S,Z,C,V}
- retired  out  16  count of operations delivered on the output handshake

## Operation
- Two registers: E (execute, drives the ALU) and W (writeback).
- e_adv = e_valid && (!w_valid || out_ready).
- in_ready = !e_valid || e_adv.
- E loads on in_valid && in_ready.
- W loads from E on e_adv. W clears on out_valid && out_ready unless it reloads on the same edge.
- alu_c_in = e_use_carry & status[C], combinational from the registered status. Back-to-back carry chains therefore see the previous op's carry without a stall.
- Flags are computed on the E contents and alu_result at e_adv, for legal opcodes:
  - S = result[15]; Z = (result == 0).
  - ADD (0): C = bit 16 of the 17-bit sum A+B+C_in; V = (A[15]==B[15]) && (result[15]!=A[15]).
  - SUB (1): C = borrow, i.e. {1'b0,A} < {1'b0,B}+C_in; V = (A[15]!=B[15]) && (result[15]!=A[15]).
  - MULT (2): C = V = (high 16 bits of the 32-bit A*B != 0).
  - All other opcodes: C = V = 0.
- status is written at e_adv only for legal, non-trapping ops.
- Opcodes 12–15 are illegal: out_result = 0, out_illegal = 1, status unchanged.
- retired increments on each output handshake and wraps 0xFFFF→0x0000.
- flush clears e_valid and w_valid at the next edge. status and retired are unchanged. Any op offered on the flush cycle is dropped; in_ready remains as computed.

## Timing
- Reset values: in_ready=1 (derived), out_valid=0, out_result=0, out_illegal=0, out_trap=0, alu_a=alu_b=0, alu_opcode=0, alu_c_in=0, status=0, retired=0.
- Latency: an op accepted at edge N appears with out_valid=1 in the cycle after edge N+1, given no backpressure.
- Sustained throughput is 1 op/cycle with out_ready held high.
- With out_ready=0, W holds, then E holds, and in_ready drops. No op is lost or duplicated.
- Output data (out_result, out_illegal, out_trap) is stable while out_valid && !out_ready.
- Flush has priority over all loads on the same edge.
- Reset may assert at any cycle and clears all state asynchronously.

## Configuration
- ALU_EXEC_DIV0_TRAP_EN defined:
  - DIV (3) with B == 0 produces out_result = 16'hFFFF and out_trap = 1; status is not written.
  - The output handshake still occurs and retired still increments.
- ALU_EXEC_DIV0_TRAP_EN undefined:
  - out_trap is tied to 0.
  - DIV by zero passes alu_result through, and flags update by the normal rule.

## Test plan
- ADD 0xFFFF + 0x0001, use_carry=0 -> out_result=0x0000, status {S,Z,C,V} = 0,1,1,0.
- Carry chain: ADD 0xFFFF+0x0001, then ADD 0x0000+0x0000 with use_carry=1, issued back-to-back -> second result 0x0001, status 0,0,0,0.
- SUB 0x8000 − 0x0001 -> 0x7FFF, status 0,0,0,1. SUB 0x0001 − 0x0002 -> 0xFFFF, status 1,0,1,0.
- Backpressure: 5 ops streamed, out_ready low for 3 cycles mid-stream -> all 5 results delivered in order, none dropped, retired = 5.
- Illegal opcode 13 -> out_illegal=1, out_result=0, status unchanged. With ALU_EXEC_DIV0_TRAP_EN, DIV 0x1234/0 -> out_trap=1, out_result=0xFFFF, status unchanged.
- Flush with both E and W full -> out_valid=0 next cycle. The next op accepted after the flush delivers normally. rst_n pulsed mid-stream -> all outputs at their reset values.
